// File: rtl/frame_scheduler_pkg.sv
// frame_scheduler_pkg
//   Shared types and helpers for the raster scheduler / framebuffer writer.
//   - DEF_WIDTH / DEF_HEIGHT : default frame geometry
//   - fb_word_t              : one RGB565 framebuffer word
//   - to_rgb565()            : packs 8-bit R/G/B into RGB565
//   - sched_state_t          : scheduler states (PRIME, RUN)
package frame_scheduler_pkg;

    localparam int DEF_WIDTH  = 1280;
    localparam int DEF_HEIGHT = 720;

    typedef logic [15:0] fb_word_t;

    typedef enum logic {
        PRIME,
        RUN
    } sched_state_t;

    function automatic fb_word_t to_rgb565(input logic [7:0] r,
                                           input logic [7:0] g,
                                           input logic [7:0] b);
        return {r[7:3], g[7:2], b[7:3]};
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo
//   Synchronous first-word-fall-through FIFO holding pending framebuffer writes.
//   Ports:
//     clk_in, rst_in : clock, async active-high reset (empties the FIFO)
//     push, din      : write request / data (ignored when full unless popping)
//     pop            : consume head (ignored when empty)
//     dout           : current head, valid whenever !empty
//     empty, full    : occupancy flags
module pixel_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              empty,
    output logic              full
);

    localparam int PW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PW:0]       r_wp;
    logic [PW:0]       r_rp;
    logic              w_wr;
    logic              w_rd;

    assign empty = (r_wp == r_rp);
    assign full  = (r_wp[PW] != r_rp[PW]) && (r_wp[PW-1:0] == r_rp[PW-1:0]);
    // A push into a full FIFO is fine when the head leaves in the same cycle.
    assign w_wr  = push && (!full || pop);
    assign w_rd  = pop && !empty;
    assign dout  = r_mem[r_rp[PW-1:0]];

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_wr) r_mem[r_wp[PW-1:0]] <= din;
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Raster sequencer and framebuffer writer for the raymarcher.
//   Ports:
//     clk_in, rst_in              : clock, async active-high reset
//     pixel_done, red/green/blue_in, px_x, px_y : finished pixel from raymarcher
//     curr_x, curr_y              : next coordinate for the raymarcher to sample
//     fb_ready, fb_we, fb_addr, fb_data : framebuffer write port (FWFT FIFO head)
//     frame_done, frame_count     : frame completion pulse / completed frame counter
//     overflow, coord_err         : sticky error flags
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int BUF_DEPTH = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              pixel_done,
    input  logic [7:0]                        red_in,
    input  logic [7:0]                        green_in,
    input  logic [7:0]                        blue_in,
    input  logic [$clog2(WIDTH)-1:0]          px_x,
    input  logic [$clog2(HEIGHT)-1:0]         px_y,
    output logic [$clog2(WIDTH)-1:0]          curr_x,
    output logic [$clog2(HEIGHT)-1:0]         curr_y,
    input  logic                              fb_ready,
    output logic                              fb_we,
    output logic [$clog2(WIDTH*HEIGHT)-1:0]   fb_addr,
    output logic [15:0]                       fb_data,
    output logic                              frame_done,
    output logic [15:0]                       frame_count,
    output logic                              overflow,
    output logic                              coord_err
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH*HEIGHT);
    localparam int EW = 1 + AW + 16;   // {last, addr, rgb565}

    sched_state_t   r_state, w_state_nxt;
    logic [XW-1:0]  r_cx;
    logic [YW-1:0]  r_cy;
    logic           r_frame_done;
    logic [15:0]    r_frame_count;
    logic           r_overflow;
    logic           r_coord_err;

    logic           w_run_px;
    logic           w_in_range;
    logic           w_last;
    logic           w_mism;
    logic           w_push;
    logic           w_pop;
    logic           w_empty;
    logic           w_full;
    logic [AW-1:0]  w_addr;
    logic [EW-1:0]  w_entry;
    logic [EW-1:0]  w_head;

    // Compare in one extra bit so a power-of-two WIDTH/HEIGHT is not truncated to 0.
    assign w_in_range = ({1'b0, px_x} < (XW+1)'(WIDTH)) && ({1'b0, px_y} < (YW+1)'(HEIGHT));
    assign w_last     = (px_x == XW'(WIDTH-1)) && (px_y == YW'(HEIGHT-1));
    assign w_addr     = AW'(px_y) * AW'(WIDTH) + AW'(px_x);
    assign w_entry    = {w_last, w_addr, to_rgb565(red_in, green_in, blue_in)};

    // curr is the coordinate the raymarcher was sampling when this pixel_done
    // arrived, so it doubles as the expected raster position.
    assign w_run_px = pixel_done && (r_state == RUN);
    assign w_mism   = w_run_px && (!w_in_range || px_x != r_cx || px_y != r_cy);
    assign w_push   = w_run_px && w_in_range;
    assign w_pop    = fb_we && fb_ready;

    pixel_fifo #(.DATA_W(EW), .DEPTH(BUF_DEPTH)) u_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (w_push),
        .pop    (w_pop),
        .din    (w_entry),
        .dout   (w_head),
        .empty  (w_empty),
        .full   (w_full)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            PRIME:   if (pixel_done) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = PRIME;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) r_state <= PRIME;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_cx          <= '0;
            r_cy          <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
            r_coord_err   <= 1'b0;
        end else begin
            if (w_run_px) begin
                if (r_cx == XW'(WIDTH-1)) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == YW'(HEIGHT-1)) ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end
            if (w_mism) r_coord_err <= 1'b1;
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
            r_frame_done <= w_pop && w_head[EW-1];
            if (w_pop && w_head[EW-1]) r_frame_count <= r_frame_count + 1'b1;
        end
    end

    assign curr_x      = r_cx;
    assign curr_y      = r_cy;
    assign fb_we       = !w_empty;
    assign fb_addr     = w_head[AW+15:16];
    assign fb_data     = w_head[15:0];
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign overflow    = r_overflow;
    assign coord_err   = r_coord_err;

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    // 5x3 frame keeps runs short and leaves room for out-of-range coordinates.
    localparam int W  = 5;
    localparam int H  = 3;
    localparam int BD = 4;

    logic        gclk = 1'b0;
    logic        rst_in;
    logic        pixel_done;
    logic [7:0]  red_in, green_in, blue_in;
    logic [2:0]  px_x;
    logic [1:0]  px_y;
    logic [2:0]  curr_x;
    logic [1:0]  curr_y;
    logic        fb_ready;
    logic        fb_we;
    logic [3:0]  fb_addr;
    logic [15:0] fb_data;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        overflow;
    logic        coord_err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 gclk = ~gclk;

    frame_scheduler #(.WIDTH(W), .HEIGHT(H), .BUF_DEPTH(BD)) dut (
        .clk_in      (gclk),
        .rst_in      (rst_in),
        .pixel_done  (pixel_done),
        .red_in      (red_in),
        .green_in    (green_in),
        .blue_in     (blue_in),
        .px_x        (px_x),
        .px_y        (px_y),
        .curr_x      (curr_x),
        .curr_y      (curr_y),
        .fb_ready    (fb_ready),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .frame_done  (frame_done),
        .frame_count (frame_count),
        .overflow    (overflow),
        .coord_err   (coord_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge gclk);
        #1;
    endtask

    // One-cycle pixel_done strobe; returns 1 time unit after the capturing edge.
    task automatic pix(input int x, input int y, input int r, input int g, input int b);
        pixel_done = 1'b1;
        px_x       = 3'(x);
        px_y       = 2'(y);
        red_in     = 8'(r);
        green_in   = 8'(g);
        blue_in    = 8'(b);
        tick();
        pixel_done = 1'b0;
    endtask

    function automatic logic [15:0] rgb_of(input int i);
        logic [4:0] f5;
        logic [5:0] f6;
        f5 = 5'(i);
        f6 = 6'(i);
        return {f5, f6, f5};
    endfunction

    initial begin
        rst_in = 1'b1; pixel_done = 1'b0; fb_ready = 1'b0;
        red_in = '0; green_in = '0; blue_in = '0; px_x = '0; px_y = '0;
        tick(); tick();
        chk("rst_curr_x", curr_x, 0);
        chk("rst_curr_y", curr_y, 0);
        chk("rst_fb_we", fb_we, 0);
        chk("rst_flags", {overflow, coord_err, frame_done}, 0);
        chk("rst_fcount", frame_count, 0);
        rst_in = 1'b0;
        tick();

        // 1. PRIME pixel discarded
        pix(2, 2, 8'hAA, 8'hBB, 8'hCC);
        chk("prime_we", fb_we, 0);
        chk("prime_curr", {curr_y, curr_x}, 0);
        chk("prime_cerr", coord_err, 0);

        // 2. first real pixel
        fb_ready = 1'b1;
        pix(0, 0, 8'hFF, 8'h80, 8'h08);
        chk("p0_curr_x", curr_x, 1);
        chk("p0_we", fb_we, 1);
        chk("p0_addr", fb_addr, 0);
        chk("p0_data", fb_data, 16'hFC01);
        tick();
        chk("p0_popped", fb_we, 0);

        // 3. rest of the frame, in order
        for (int i = 1; i < W*H; i++) begin
            pix(i % W, i / W, 8*i, 4*i, 8*i);
            chk("frm_addr", fb_addr, i);
            chk("frm_data", fb_data, rgb_of(i));
        end
        chk("frm_wrap", {curr_y, curr_x}, 0);
        chk("frm_done_early", frame_done, 0);
        tick();
        chk("frm_done", frame_done, 1);
        chk("frm_count", frame_count, 1);
        chk("frm_drained", fb_we, 0);
        tick();
        chk("frm_done_pulse", frame_done, 0);
        chk("frm_cerr", coord_err, 0);

        // 4. overflow under backpressure
        fb_ready = 1'b0;
        for (int k = 0; k <= BD; k++) pix(k, 0, 8*k, 4*k, 8*k);
        chk("ovf_flag", overflow, 1);
        chk("ovf_curr", {curr_y, curr_x}, {2'd1, 3'd0});
        tick(); tick();
        chk("ovf_hold_we", fb_we, 1);
        chk("ovf_hold_addr", fb_addr, 0);
        chk("ovf_hold_data", fb_data, rgb_of(0));
        fb_ready = 1'b1;
        for (int k = 0; k < BD; k++) begin
            chk("ovf_drain_addr", fb_addr, k);
            chk("ovf_drain_data", fb_data, rgb_of(k));
            tick();
        end
        chk("ovf_empty", fb_we, 0);
        chk("ovf_fcount", frame_count, 1);

        // 5a. out-of-order coordinate (expected (0,1)) still written
        pix(2, 1, 8'h10, 8'h20, 8'h30);
        chk("cerr_set", coord_err, 1);
        chk("cerr_we", fb_we, 1);
        chk("cerr_addr", fb_addr, 7);
        tick();

        // 6. reset mid-drain
        fb_ready = 1'b0;
        pix(1, 1, 8'h40, 8'h40, 8'h40);
        chk("mid_we", fb_we, 1);
        #2 rst_in = 1'b1;
        #1;
        chk("mid_rst_we", fb_we, 0);
        chk("mid_rst_flags", {overflow, coord_err}, 0);
        chk("mid_rst_curr", {curr_y, curr_x}, 0);
        tick();
        rst_in = 1'b0;
        fb_ready = 1'b1;
        tick();
        pix(3, 0, 8'h11, 8'h22, 8'h33);
        chk("reprime_we", fb_we, 0);
        chk("reprime_curr", {curr_y, curr_x}, 0);

        // 5b. out-of-range x: flagged, dropped, raster still advances
        pix(W, 0, 8'h55, 8'h55, 8'h55);
        chk("oor_cerr", coord_err, 1);
        chk("oor_we", fb_we, 0);
        chk("oor_curr", {curr_y, curr_x}, {2'd0, 3'd1});
        pix(1, 0, 8'hFF, 8'hFF, 8'hFF);
        chk("post_we", fb_we, 1);
        chk("post_addr", fb_addr, 1);
        chk("post_data", fb_data, 16'hFFFF);
        chk("post_fcount", frame_count, 0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
